// File: rtl/sci2_tx_sched.sv
// SCI2 command-line transmitter: round-robin choice between two requesters, 13-bit
// word framing, LSB-first serialization on a differential pair, then an idle gap.
module sci2_tx_sched #(
  parameter int BIT_DIV  = 2,
  parameter int GAP_BITS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req0_cmd,
  input  logic        req0_group,
  input  logic [4:0]  req0_addr,
  input  logic [35:0] req0_info,
  input  logic [2:0]  req0_len,
  input  logic [2:0]  req1_cmd,
  input  logic        req1_group,
  input  logic [4:0]  req1_addr,
  input  logic [35:0] req1_info,
  input  logic [2:0]  req1_len,
  output logic        data_a,
  output logic        data_b,
  output logic        busy,
  output logic        grant,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] DIV_LAST = 16'(BIT_DIV - 1);
  // The line output lags the state by one register, so GAP lasts one extra cycle.
  localparam logic [15:0] GAP_LAST = 16'(GAP_BITS * BIT_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  req_ready_q, req_ready_d;
  logic        data_a_q, data_a_d;
  logic        busy_q, busy_d;
  logic        grant_q, grant_d;
  logic        rr_q, rr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        group_q, group_d;
  logic [4:0]  addr_q, addr_d;
  logic [35:0] info_q, info_d;
  logic [2:0]  len_q, len_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  word_q, word_d;
  logic [15:0] gap_q, gap_d;

  logic        win;
  logic [2:0]  sel_len;
  logic        len_ok_q;
  logic        mark;
  logic [8:0]  cur_data;
  logic [12:0] frame;
  logic [8:0]  word_data [0:4];

  assign word_data[0] = {cmd_q, group_q, addr_q};
  generate
    for (genvar gi = 1; gi < 5; gi++) begin : g_info
      assign word_data[gi] = info_q[9*(gi-1) +: 9];
    end
  endgenerate

  assign len_ok_q = (len_q != 3'd0) && (len_q <= 3'd5);

  // Frame: stop, odd parity over data+mark, mark, data, start (bit 0 is sent first).
  always_comb begin
    cur_data = word_data[word_q];
    mark     = (word_q == 3'd0);
    frame    = {1'b1, ~^{mark, cur_data}, mark, cur_data, 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = 2'b00;
    busy_d      = busy_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    done_d      = 1'b0;
    err_d       = (req_ready_q != 2'b00) && !len_ok_q;
    data_a_d    = (state_q == S_SHIFT) ? frame[bit_q] : 1'b1;
    cmd_d       = cmd_q;
    group_d     = group_q;
    addr_d      = addr_q;
    info_d      = info_q;
    len_d       = len_q;
    div_d       = div_q;
    bit_d       = bit_q;
    word_d      = word_q;
    gap_d       = gap_q;
    win         = 1'b0;
    sel_len     = req0_len;

    case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          win         = (req_valid == 2'b11) ? rr_q : req_valid[1];
          sel_len     = win ? req1_len : req0_len;
          req_ready_d = win ? 2'b10 : 2'b01;
          grant_d     = win;
          rr_d        = ~win;
          busy_d      = 1'b1;
          cmd_d       = win ? req1_cmd   : req0_cmd;
          group_d     = win ? req1_group : req0_group;
          addr_d      = win ? req1_addr  : req0_addr;
          info_d      = win ? req1_info  : req0_info;
          len_d       = sel_len;
          div_d       = 16'd0;
          bit_d       = 4'd0;
          word_d      = 3'd0;
          gap_d       = 16'd0;
          // Illegal lengths skip straight to the gap so the requester still gets a done.
          state_d     = ((sel_len != 3'd0) && (sel_len <= 3'd5)) ? S_SHIFT : S_GAP;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 16'd0;
          if (bit_q == 4'd12) begin
            bit_d = 4'd0;
            if (word_q == len_q - 3'd1) begin
              word_d  = 3'd0;
              state_d = S_GAP;
            end else begin
              word_d = word_q + 3'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 16'd0;
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 2'b00;
      data_a_q    <= 1'b1;
      busy_q      <= 1'b0;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_q       <= 3'd0;
      group_q     <= 1'b0;
      addr_q      <= 5'd0;
      info_q      <= 36'd0;
      len_q       <= 3'd0;
      div_q       <= 16'd0;
      bit_q       <= 4'd0;
      word_q      <= 3'd0;
      gap_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      data_a_q    <= data_a_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_q       <= cmd_d;
      group_q     <= group_d;
      addr_q      <= addr_d;
      info_q      <= info_d;
      len_q       <= len_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      gap_q       <= gap_d;
    end
  end

  assign req_ready = req_ready_q;
  assign data_a    = data_a_q;
  assign data_b    = ~data_a_q;
  assign busy      = busy_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sci2_tx_sched.sv
// Self-checking bench for sci2_tx_sched: randomized commands compared against a
// frame-level model of the SCI2 line (bit stream, gap, done/err timing, arbitration).
module tb_sci2_tx_sched;
  localparam int BD = 2;
  localparam int GB = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [2:0]  req0_cmd = 3'd0, req1_cmd = 3'd0;
  logic        req0_group = 1'b0, req1_group = 1'b0;
  logic [4:0]  req0_addr = 5'd0, req1_addr = 5'd0;
  logic [35:0] req0_info = 36'd0, req1_info = 36'd0;
  logic [2:0]  req0_len = 3'd1, req1_len = 3'd1;
  logic        data_a, data_b, busy, grant, done, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit exp_rr = 1'b0;

  logic [2:0]  f_cmd [2];
  logic        f_grp [2];
  logic [4:0]  f_addr[2];
  logic [35:0] f_info[2];
  logic [2:0]  f_len [2];

  logic exp_bits[$];
  logic line_s[$];
  int   acc_cyc, done_cyc, err_cyc, dbad, busy_bad;
  logic [1:0] ready_seen;
  logic grant_seen, busy_at_done;
  bit   timed_out;

  sci2_tx_sched #(.BIT_DIV(BD), .GAP_BITS(GB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req0_group(req0_group), .req0_addr(req0_addr),
    .req0_info(req0_info), .req0_len(req0_len),
    .req1_cmd(req1_cmd), .req1_group(req1_group), .req1_addr(req1_addr),
    .req1_info(req1_info), .req1_len(req1_len),
    .data_a(data_a), .data_b(data_b), .busy(busy), .grant(grant),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_fields(input int r, input logic [2:0] c, input logic g,
                            input logic [4:0] a, input logic [35:0] inf, input logic [2:0] l);
    f_cmd[r] = c; f_grp[r] = g; f_addr[r] = a; f_info[r] = inf; f_len[r] = l;
    if (r == 0) begin
      req0_cmd = c; req0_group = g; req0_addr = a; req0_info = inf; req0_len = l;
    end else begin
      req1_cmd = c; req1_group = g; req1_addr = a; req1_info = inf; req1_len = l;
    end
  endtask

  task automatic set_random(input int r, input logic [2:0] l);
    set_fields(r, 3'($urandom()), 1'($urandom()), 5'($urandom()),
               {4'($urandom()), $urandom()}, l);
  endtask

  // Reference line model: expected bit sequence for a legal command of requester r.
  function automatic void build_frames(input int r);
    logic [8:0] d;
    logic mk;
    exp_bits.delete();
    if (f_len[r] >= 3'd1 && f_len[r] <= 3'd5) begin
      for (int w = 0; w < int'(f_len[r]); w++) begin
        if (w == 0) d = {f_cmd[r], f_grp[r], f_addr[r]};
        else        d = f_info[r][9*(w-1) +: 9];
        mk = (w == 0);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 9; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(mk);
        exp_bits.push_back(($countones({d, mk}) % 2) == 0);
        exp_bits.push_back(1'b1);
      end
    end
  endfunction

  // Index of the first line bit that disagrees with the model (size() = gap problem), or -1.
  function automatic int first_bad();
    int n;
    n = exp_bits.size() * BD;
    for (int j = 0; j < exp_bits.size(); j++)
      for (int t = 0; t < BD; t++)
        if (j*BD + t >= line_s.size() || line_s[j*BD + t] !== exp_bits[j]) return j;
    for (int idx = n; idx < n + GB*BD; idx++)
      if (idx >= line_s.size() || line_s[idx] !== 1'b1) return exp_bits.size();
    return -1;
  endfunction

  // Raise valid, wait for the accept, then record the line until done (bounded).
  task automatic capture(input logic [1:0] mask);
    acc_cyc = -1; done_cyc = -1; err_cyc = -1; dbad = 0; busy_bad = 0;
    timed_out = 1'b0; ready_seen = 2'b00; grant_seen = 1'b0; busy_at_done = 1'b1;
    line_s.delete();
    req_valid = mask;
    for (int k = 0; k < 200 && acc_cyc < 0; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        acc_cyc = cyc; ready_seen = req_ready; grant_seen = grant;
        req_valid = req_valid & ~req_ready;
        set_random(req_ready[1] ? 1 : 0, 3'($urandom()));
      end
    end
    if (acc_cyc < 0) begin
      timed_out = 1'b1;
      $display("txn: mask=%b no accept", mask);
      return;
    end
    for (int k = 0; k < 3000 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (data_b !== ~data_a) dbad++;
      if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
      if (done === 1'b1) begin
        done_cyc = cyc; busy_at_done = busy;
      end else begin
        line_s.push_back(data_a);
        if (busy !== 1'b1) busy_bad++;
      end
    end
    if (done_cyc < 0) timed_out = 1'b1;
    $display("txn: ready=%b grant=%0d accept@%0d done@%0d err@%0d samples=%0d",
             ready_seen, grant_seen, acc_cyc, done_cyc, err_cyc, line_s.size());
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data_a !== 1'b1) begin errors++; $display("FAIL reset_data_a got=%b exp=1", data_a); end
    checks++; if (data_b !== 1'b0) begin errors++; $display("FAIL reset_data_b got=%b exp=0", data_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (grant !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got grant=%b done=%b err=%b exp=0,0,0", grant, done, err);
    end
    rst_n = 1'b1;
    exp_rr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (data_a !== 1'b1 || data_b !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_100 got bad_cycles=%0d exp=0", bad); end
    $display("txn: idle 100 cycles after reset");
  endtask

  task automatic test_round_robin();
    int prev_done = -1;
    bit w;
    for (int i = 0; i < 4; i++) begin
      set_random(0, 3'd1);
      set_random(1, 3'd1);
      w = exp_rr;
      build_frames(w ? 1 : 0);
      capture(2'b11);
      checks++; if (timed_out) begin errors++; $display("FAIL rr_timeout got=timeout exp=done"); end
      checks++; if (ready_seen !== (w ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_ready got=%b exp=%b", ready_seen, w ? 2'b10 : 2'b01);
      end
      checks++; if (grant_seen !== w) begin errors++; $display("FAIL rr_grant got=%b exp=%b", grant_seen, w); end
      checks++; if (first_bad() != -1) begin errors++; $display("FAIL rr_bits got=bad_bit_%0d exp=-1", first_bad()); end
      if (i > 0) begin
        checks++; if (acc_cyc != prev_done + 1) begin
          errors++; $display("FAIL rr_next_accept got=%0d exp=%0d", acc_cyc, prev_done + 1);
        end
      end
      prev_done = done_cyc;
      exp_rr = ~w;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_frame_fixed();
    set_fields(0, 3'd1, 1'b0, 5'd1, 36'h084, 3'd2);
    build_frames(0);
    capture(2'b01);
    checks++; if (timed_out) begin errors++; $display("FAIL fixed_timeout got=timeout exp=done"); end
    checks++; if (ready_seen !== 2'b01 || grant_seen !== 1'b0) begin
      errors++; $display("FAIL fixed_accept got ready=%b grant=%b exp ready=01 grant=0", ready_seen, grant_seen);
    end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL fixed_bits got=bad_bit_%0d exp=-1", first_bad()); end
    checks++; if (done_cyc - acc_cyc != 63) begin errors++; $display("FAIL fixed_done_latency got=%0d exp=63", done_cyc - acc_cyc); end
    checks++; if (err_cyc != -1) begin errors++; $display("FAIL fixed_err got=%0d exp=-1", err_cyc); end
    checks++; if (dbad != 0 || busy_bad != 0 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL fixed_pair_busy got dbad=%0d busy_bad=%0d busy_at_done=%b exp 0,0,0", dbad, busy_bad, busy_at_done);
    end
    exp_rr = 1'b1;
  endtask

  task automatic test_len5();
    set_fields(1, 3'($urandom()), 1'($urandom()), 5'($urandom()), 36'hF_FFFF_FFFF, 3'd5);
    build_frames(1);
    capture(2'b10);
    checks++; if (timed_out) begin errors++; $display("FAIL len5_timeout got=timeout exp=done"); end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL len5_bits got=bad_bit_%0d exp=-1", first_bad()); end
    checks++; if (done_cyc - acc_cyc != 1 + (65 + GB)*BD) begin
      errors++; $display("FAIL len5_done_latency got=%0d exp=%0d", done_cyc - acc_cyc, 1 + (65 + GB)*BD);
    end
    exp_rr = 1'b0;
  endtask

  task automatic test_illegal_len();
    logic [2:0] lens [3];
    int r;
    lens[0] = 3'd0; lens[1] = 3'd6; lens[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      r = (i == 1) ? 0 : 1;
      set_random(r, lens[i]);
      build_frames(r);
      capture(r == 1 ? 2'b10 : 2'b01);
      checks++; if (timed_out) begin errors++; $display("FAIL illegal_timeout len=%0d got=timeout exp=done", lens[i]); end
      checks++; if (err_cyc != acc_cyc + 1) begin
        errors++; $display("FAIL illegal_err len=%0d got=%0d exp=%0d", lens[i], err_cyc, acc_cyc + 1);
      end
      checks++; if (line_s.size() != GB*BD || first_bad() != -1) begin
        errors++; $display("FAIL illegal_line len=%0d got samples=%0d bad=%0d exp=%0d,-1", lens[i], line_s.size(), first_bad(), GB*BD);
      end
      checks++; if (done_cyc - acc_cyc != 1 + GB*BD) begin
        errors++; $display("FAIL illegal_done len=%0d got=%0d exp=%0d", lens[i], done_cyc - acc_cyc, 1 + GB*BD);
      end
      exp_rr = (r == 0);
    end
  endtask

  task automatic test_reset_midshift();
    int acc = -1;
    int bad = 0;
    set_random(0, 3'd2);
    build_frames(0);
    req_valid = 2'b01;
    for (int k = 0; k < 200 && acc < 0; k++) begin
      @(negedge clk);
      if (req_ready[0] === 1'b1) begin acc = cyc; req_valid = 2'b00; end
    end
    checks++;
    if (acc < 0) begin
      errors++; $display("FAIL midrst_accept got=timeout exp=accept"); req_valid = 2'b00; return;
    end
    while (cyc < acc + 1 + 20*BD) @(negedge clk);
    checks++; if (data_a !== exp_bits[20]) begin errors++; $display("FAIL midrst_bit20 got=%b exp=%b", data_a, exp_bits[20]); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (data_a !== 1'b1 || data_b !== 1'b0) begin
      errors++; $display("FAIL midrst_line got a=%b b=%b exp a=1 b=0", data_a, data_b);
    end
    checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL midrst_busy got busy=%b ready=%b exp 0,00", busy, req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rr = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || data_a !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet got bad_cycles=%0d exp=0", bad); end
    $display("txn: reset at word1 bit7, accept@%0d", acc);
    set_random(1, 3'($urandom_range(1, 5)));
    build_frames(1);
    capture(2'b10);
    checks++; if (timed_out || ready_seen !== 2'b10) begin
      errors++; $display("FAIL midrst_fresh_accept got ready=%b timeout=%0d exp ready=10", ready_seen, timed_out);
    end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL midrst_fresh_bits got=bad_bit_%0d exp=-1", first_bad()); end
    exp_rr = 1'b0;
  endtask

  task automatic test_random();
    int r;
    int l;
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 1));
      l = int'($urandom_range(1, 5));
      set_random(r, 3'(l));
      build_frames(r);
      capture(r == 1 ? 2'b10 : 2'b01);
      checks++; if (timed_out || grant_seen !== 1'(r)) begin
        errors++; $display("FAIL rand_accept i=%0d got grant=%b timeout=%0d exp grant=%0d", i, grant_seen, timed_out, r);
      end
      checks++; if (first_bad() != -1) begin errors++; $display("FAIL rand_bits i=%0d got=bad_bit_%0d exp=-1", i, first_bad()); end
      checks++; if (done_cyc - acc_cyc != 1 + (l*13 + GB)*BD) begin
        errors++; $display("FAIL rand_done i=%0d got=%0d exp=%0d", i, done_cyc - acc_cyc, 1 + (l*13 + GB)*BD);
      end
      checks++; if (err_cyc != -1 || dbad != 0 || busy_bad != 0) begin
        errors++; $display("FAIL rand_flags i=%0d got err@%0d dbad=%0d busy_bad=%0d exp -1,0,0", i, err_cyc, dbad, busy_bad);
      end
      exp_rr = (r == 0);
    end
  endtask

  initial begin
    for (int r = 0; r < 2; r++) set_fields(r, 3'd0, 1'b0, 5'd0, 36'd0, 3'd1);
    test_reset();
    test_round_robin();
    test_frame_fixed();
    test_len5();
    test_illegal_len();
    test_reset_midshift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
